// File: rtl/vid_capture_st_if.sv
// Avalon-ST video source bundle: the capture block drives it (master),
// the downstream sink consumes it (slave).
interface vid_capture_st_if;
  logic [23:0] source_data;
  logic        source_valid;
  logic        source_ready;
  logic        source_startofpacket;
  logic        source_endofpacket;

  modport master (
    output source_data, source_valid, source_startofpacket, source_endofpacket,
    input  source_ready
  );
  modport slave (
    input  source_data, source_valid, source_startofpacket, source_endofpacket,
    output source_ready
  );
endinterface

// File: rtl/vid_capture_st.sv
// Clocked-video to Avalon-ST video packetizer with a FWFT output FIFO.
// Truncated or overflowed frames are closed with a zero-data eop terminator beat.
module vid_capture_st #(
  parameter int FRAME_W    = 640,
  parameter int FRAME_H    = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] vid_data,
  input  logic        vid_datavalid,
  input  logic        vid_v_sync,
  input  logic        vid_h_sync,
  input  logic        clear_err,
  output logic        overflow,
  output logic        short_frame,
  vid_capture_st_if.master src
);
  localparam int TOTAL = FRAME_W * FRAME_H;
  localparam int CW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int LW    = $clog2(FRAME_H + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_PIX  = CW'(TOTAL - 1);
  // Beat layout {data, sop, eop}
  localparam logic [25:0]   BEAT_HDR  = {24'h000000, 1'b1, 1'b0};
  localparam logic [25:0]   BEAT_TERM = {24'h000000, 1'b0, 1'b1};

  typedef enum logic [1:0] {IDLE, HDR, ACTIVE, DROP} state_t;
  state_t st, nxt;

  logic          vs_q, hs_q, vs_edge;
  logic [CW-1:0] cnt;
  logic [LW-1:0] line_cnt;
  logic          term_pend, term_nxt;
  logic          push, cnt_clr, cnt_inc, set_ovf, set_short, last;
  logic [25:0]   push_beat;

  logic [25:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fcnt;
  logic          full, empty, pop;
  logic [25:0]   rd_beat;

  assign vs_edge = vid_v_sync & ~vs_q;
  assign last    = (cnt == LAST_PIX);
  assign full    = (fcnt == (AW+1)'(FIFO_DEPTH));
  assign empty   = (fcnt == '0);
  assign pop     = ~empty & src.source_ready;
  assign rd_beat = mem[rd_ptr];

  assign src.source_valid         = ~empty;
  assign src.source_data          = empty ? 24'h0 : rd_beat[25:2];
  assign src.source_startofpacket = ~empty & rd_beat[1];
  assign src.source_endofpacket   = ~empty & rd_beat[0];

  always_comb begin
    nxt       = st;
    push      = 1'b0;
    push_beat = '0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    set_ovf   = 1'b0;
    set_short = 1'b0;
    term_nxt  = term_pend;
    case (st)
      IDLE: if (vs_edge) nxt = HDR;
      HDR: begin
        // A pending terminator always leaves the FIFO ahead of the next header
        if (!full) begin
          push = 1'b1;
          if (term_pend) begin
            push_beat = BEAT_TERM;
            term_nxt  = 1'b0;
          end else begin
            push_beat = BEAT_HDR;
            cnt_clr   = 1'b1;
            nxt       = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        if (vs_edge) begin
          set_short = 1'b1;
          nxt       = HDR;
          if (full) term_nxt = 1'b1;
          else begin
            push      = 1'b1;
            push_beat = BEAT_TERM;
          end
        end else if (vid_datavalid) begin
          if (full) begin
            set_ovf = 1'b1;
            nxt     = DROP;
          end else begin
            push      = 1'b1;
            push_beat = {vid_data, 1'b0, last};
            cnt_inc   = 1'b1;
            if (last) nxt = IDLE;
          end
        end
      end
      DROP: begin
        if (vs_edge) begin
          nxt = HDR;
          if (full) term_nxt = 1'b1;
          else begin
            push      = 1'b1;
            push_beat = BEAT_TERM;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st          <= IDLE;
      vs_q        <= 1'b0;
      hs_q        <= 1'b0;
      cnt         <= '0;
      line_cnt    <= '0;
      term_pend   <= 1'b0;
      overflow    <= 1'b0;
      short_frame <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fcnt        <= '0;
    end else begin
      st          <= nxt;
      vs_q        <= vid_v_sync;
      hs_q        <= vid_h_sync;
      term_pend   <= term_nxt;
      overflow    <= set_ovf   | (overflow    & ~clear_err);
      short_frame <= set_short | (short_frame & ~clear_err);
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (cnt_clr)                                         line_cnt <= '0;
      else if (st == ACTIVE && vid_h_sync && !hs_q)        line_cnt <= line_cnt + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fcnt <= fcnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Storage carries no reset; the read side is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_beat;
  end
endmodule

// File: tb/tb_vid_capture_st.sv
// Randomized + directed bench for vid_capture_st against a queue-based packet model.
module tb_vid_capture_st;
  localparam int FW = 4, FH = 2, DEPTH = 4, TOTAL = FW * FH;

  logic clk = 0, rst_n = 0;
  logic [23:0] vid_data = '0;
  logic vid_datavalid = 0, vid_v_sync = 0, vid_h_sync = 0, clear_err = 0;
  logic overflow, short_frame;
  vid_capture_st_if sif();

  vid_capture_st #(.FRAME_W(FW), .FRAME_H(FH), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(rst_n), .vid_data(vid_data), .vid_datavalid(vid_datavalid),
    .vid_v_sync(vid_v_sync), .vid_h_sync(vid_h_sync), .clear_err(clear_err),
    .overflow(overflow), .short_frame(short_frame), .src(sif.master)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [25:0] log_q[$];

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // Packet model: expected FIFO contents as a queue plus frame bookkeeping.
  logic [25:0] mq[$];
  bit m_started = 0, m_vs_prev = 0, m_in_pkt = 0, m_dropping = 0;
  bit m_need_hdr = 0, m_term_owed = 0, m_ovf = 0, m_short = 0;
  int m_pix = 0;

  always @(posedge clk) begin
    bit edge_s, full, so, ss, have;
    logic [25:0] item;
    m_started = 1;
    if (!rst_n) begin
      mq.delete();
      {m_vs_prev, m_in_pkt, m_dropping, m_need_hdr, m_term_owed, m_ovf, m_short} = '0;
      m_pix = 0;
    end else begin
      edge_s = vid_v_sync && !m_vs_prev;
      m_vs_prev = vid_v_sync;
      full = (mq.size() == DEPTH);
      so = 0; ss = 0; have = 0; item = '0;
      if (m_term_owed) begin
        if (!full) begin have = 1; item = 26'h1; m_term_owed = 0; end
      end else if (m_need_hdr) begin
        if (!full) begin have = 1; item = 26'h2; m_need_hdr = 0; m_in_pkt = 1; m_pix = 0; end
      end else if (edge_s) begin
        if (m_in_pkt || m_dropping) begin
          ss = m_in_pkt;
          if (!full) begin have = 1; item = 26'h1; end
          else m_term_owed = 1;
        end
        m_in_pkt = 0; m_dropping = 0; m_need_hdr = 1;
      end else if (m_in_pkt && vid_datavalid) begin
        if (full) begin so = 1; m_in_pkt = 0; m_dropping = 1; end
        else begin
          have = 1;
          item = {vid_data, 1'b0, m_pix == TOTAL - 1};
          m_pix++;
          if (m_pix == TOTAL) m_in_pkt = 0;
        end
      end
      if (mq.size() > 0 && sif.source_ready) void'(mq.pop_front());
      if (have) mq.push_back(item);
      m_ovf   = so | (m_ovf   & !clear_err);
      m_short = ss | (m_short & !clear_err);
    end
  end

  // Compare outputs against the model every cycle; also log accepted beats.
  always @(negedge clk) begin
    if (m_started) begin
      chk("overflow", overflow, m_ovf);
      chk("short_frame", short_frame, m_short);
      if (mq.size() == 0) begin
        chk("valid_idle", sif.source_valid, 0);
        chk("data_idle", {sif.source_data, sif.source_startofpacket, sif.source_endofpacket}, 0);
      end else begin
        chk("valid", sif.source_valid, 1);
        chk("beat", {sif.source_data, sif.source_startofpacket, sif.source_endofpacket}, mq[0]);
      end
      if (rst_n && sif.source_valid === 1'b1 && sif.source_ready)
        log_q.push_back({sif.source_data, sif.source_startofpacket, sif.source_endofpacket});
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic vs_pulse();
    vid_v_sync = 1; step(1);
    vid_v_sync = 0; step(2);
  endtask

  task automatic pixels(int n);
    for (int k = 1; k <= n; k++) begin
      vid_datavalid = 1; vid_data = 24'(k); step(1);
    end
    vid_datavalid = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; step(1); rst_n = 1;
  endtask

  task automatic chk_log(string nm, input logic [25:0] e[$]);
    chk({nm, "_len"}, log_q.size(), e.size());
    for (int i = 0; i < e.size() && i < log_q.size(); i++) chk(nm, log_q[i], e[i]);
  endtask

  function automatic void add_frame(inout logic [25:0] e[$], input int n, input bit eop_last);
    e.push_back(26'h2);
    for (int k = 1; k <= n; k++) e.push_back({24'(k), 1'b0, eop_last && k == n});
  endfunction

  initial begin
    logic [25:0] e[$];
    sif.source_ready = 1;
    step(2);
    chk("rst_valid", sif.source_valid, 0);
    chk("rst_data", sif.source_data, 0);
    chk("rst_flags", {overflow, short_frame, sif.source_startofpacket, sif.source_endofpacket}, 0);
    rst_n = 1;

    // Pixels before any v_sync are ignored
    vid_datavalid = 1; vid_data = 24'hABCDEF; step(6); vid_datavalid = 0;
    chk("pre_vsync_valid", sif.source_valid, 0);

    // Clean frame
    log_q.delete();
    vs_pulse(); pixels(TOTAL); step(3);
    e.delete(); add_frame(e, TOTAL, 1);
    chk_log("clean_frame", e);
    chk("clean_flags", {overflow, short_frame}, 0);

    // Backpressure overflow, terminator held pending then header
    do_reset(); log_q.delete();
    sif.source_ready = 0;
    vs_pulse(); pixels(TOTAL); step(1);
    chk("ovf_set", overflow, 1);
    chk("ovf_fifo_valid", sif.source_valid, 1);
    vs_pulse();
    sif.source_ready = 1; step(8);
    pixels(TOTAL); step(3);
    e.delete(); add_frame(e, 3, 0); e.push_back(26'h1); add_frame(e, TOTAL, 1);
    chk_log("ovf_seq", e);

    // Short frame
    do_reset(); log_q.delete(); sif.source_ready = 1;
    vs_pulse(); pixels(5); vs_pulse(); step(2);
    e.delete(); add_frame(e, 5, 0); e.push_back(26'h1); e.push_back(26'h2);
    chk_log("short_seq", e);
    chk("short_set", short_frame, 1);

    // Set wins over clear
    do_reset(); sif.source_ready = 0;
    vs_pulse(); pixels(3);
    vid_datavalid = 1; vid_data = 24'h4; clear_err = 1; step(1);
    vid_datavalid = 0; clear_err = 0;
    chk("ovf_set_wins", overflow, 1);
    clear_err = 1; step(1); clear_err = 0;
    chk("ovf_cleared", overflow, 0);

    // Reset mid-frame, then a clean packet
    do_reset(); sif.source_ready = 1;
    vs_pulse(); pixels(3);
    rst_n = 0; step(1);
    chk("midrst_out", {sif.source_valid, sif.source_data, sif.source_startofpacket,
                       sif.source_endofpacket, overflow, short_frame}, 0);
    rst_n = 1; step(2); log_q.delete();
    vs_pulse(); pixels(TOTAL); step(3);
    e.delete(); add_frame(e, TOTAL, 1);
    chk_log("post_rst_frame", e);

    // Randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      vid_v_sync       = ($urandom_range(0, 99) < 4);
      vid_h_sync       = ($urandom_range(0, 9) == 0);
      vid_datavalid    = ($urandom_range(0, 9) < 7);
      vid_data         = 24'($urandom);
      sif.source_ready = ($urandom_range(0, 9) < 7);
      clear_err        = ($urandom_range(0, 19) == 0);
      rst_n            = ($urandom_range(0, 999) != 0);
      step(1);
    end
    rst_n = 1; vid_v_sync = 0; vid_datavalid = 0; clear_err = 0; sif.source_ready = 1;
    step(20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
